// File: rtl/lsu_mem_issue_pkg.sv
// Shared LSU definitions: XLEN, memory access mode codes and FSM state encodings,
// plus helpers that classify a request mode against an address.
`ifndef LSU_MEM_ISSUE_DEFINES
`define LSU_MEM_ISSUE_DEFINES
`define XLEN          32
`define MEM_MODE_B    3'b000
`define MEM_MODE_H    3'b001
`define MEM_MODE_W    3'b010
`define MEM_MODE_BU   3'b100
`define MEM_MODE_HU   3'b101
`define LSU_ST_IDLE   2'd0
`define LSU_ST_ACCESS 2'd1
`define LSU_ST_SPLIT  2'd2
`define LSU_ST_DONE   2'd3
`endif

package lsu_mem_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `LSU_ST_IDLE,
    ST_ACCESS = `LSU_ST_ACCESS,
    ST_SPLIT  = `LSU_ST_SPLIT,
    ST_DONE   = `LSU_ST_DONE
  } lsu_state_e;

  function automatic logic mode_ok(input logic [2:0] m);
    case (m)
      `MEM_MODE_B, `MEM_MODE_H, `MEM_MODE_W, `MEM_MODE_BU, `MEM_MODE_HU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mode_unsigned(input logic [2:0] m);
    return (m == `MEM_MODE_BU) || (m == `MEM_MODE_HU);
  endfunction

  // Byte accesses are always aligned; undefined modes report aligned and are
  // rejected separately by mode_ok.
  function automatic logic is_aligned(input logic [2:0] m, input logic [1:0] a);
    case (m)
      `MEM_MODE_H, `MEM_MODE_HU: return (a[0] == 1'b0);
      `MEM_MODE_W:               return (a == 2'b00);
      default:                   return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] access_bytes(input logic [2:0] m);
    case (m)
      `MEM_MODE_H, `MEM_MODE_HU: return 3'd2;
      `MEM_MODE_W:               return 3'd4;
      default:                   return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_merge.sv
// Inserts one byte into a little-endian lane of an accumulator and returns the
// merged word sign/zero-extended according to the original access mode.
module lsu_byte_merge
  import lsu_mem_issue_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0] i_acc,
  input  logic [7:0]      i_byte,
  input  logic [1:0]      i_lane,
  input  logic [2:0]      i_mode,
  output logic [XLEN-1:0] o_merged,
  output logic [XLEN-1:0] o_ext
);

  always_comb begin
    o_merged = i_acc;
    o_merged[{i_lane, 3'b000} +: 8] = i_byte;
  end

  always_comb begin
    case (i_mode)
      `MEM_MODE_B:  o_ext = XLEN'($signed(o_merged[7:0]));
      `MEM_MODE_H:  o_ext = XLEN'($signed(o_merged[15:0]));
      `MEM_MODE_W:  o_ext = XLEN'($signed(o_merged[31:0]));
      `MEM_MODE_BU: o_ext = XLEN'(o_merged[7:0]);
      `MEM_MODE_HU: o_ext = XLEN'(o_merged[15:0]);
      default:      o_ext = o_merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_issue.sv
// Single-outstanding load/store issue FSM between a request port and a memory.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned H/HU/W into byte accesses.
module lsu_mem_issue
  import lsu_mem_issue_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_mode,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_mode,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  lsu_state_e      r_state, w_next;
  logic            r_we, r_err;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]      r_mode;
  logic            w_hs, w_bad, w_aligned, w_req_err;

  assign w_hs      = req_valid & (r_state == ST_IDLE);
  assign w_bad     = !mode_ok(req_mode) | (req_we & mode_unsigned(req_mode));
  assign w_aligned = is_aligned(req_mode, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]      r_cnt;
  logic            w_last;
  logic [7:0]      w_st_byte;
  logic [XLEN-1:0] w_merged, w_ext;

  assign w_req_err = w_bad;
  assign w_last    = ({1'b0, r_cnt} == access_bytes(r_mode) - 3'd1);
  assign w_st_byte = r_wdata[{r_cnt, 3'b000} +: 8];

  lsu_byte_merge #(.XLEN(XLEN)) u_merge (
    .i_acc    (r_rdata),
    .i_byte   (mem_rdata[7:0]),
    .i_lane   (r_cnt),
    .i_mode   (r_mode),
    .o_merged (w_merged),
    .o_ext    (w_ext)
  );
`else
  assign w_req_err = w_bad | !w_aligned;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Memory strobes are decoded from the state register so reset drops them at once.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mode   = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (w_hs) begin
          if (w_req_err)      w_next = ST_DONE;
          else if (w_aligned) w_next = ST_ACCESS;
`ifdef LSU_MISALIGN_SPLIT_EN
          else                w_next = ST_SPLIT;
`endif
        end
      end
      ST_ACCESS: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_mode  = r_mode;
        mem_we    = r_we;
        mem_re    = !r_we;
        w_next    = ST_DONE;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPLIT: begin
        mem_addr  = r_addr + XLEN'(r_cnt);
        mem_wdata = XLEN'(w_st_byte);
        mem_mode  = r_we ? `MEM_MODE_B : `MEM_MODE_BU;
        mem_we    = r_we;
        mem_re    = !r_we;
        if (w_last) w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = r_rdata;
        resp_err   = r_err;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_rdata is cleared at the handshake so stores and refused requests answer 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mode  <= '0;
      r_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      if (w_hs) begin
        r_we    <= req_we;
        r_err   <= w_req_err;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mode  <= req_mode;
        r_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_cnt   <= '0;
`endif
      end else if (r_state == ST_ACCESS && !r_we) begin
        r_rdata <= mem_rdata;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      else if (r_state == ST_SPLIT) begin
        r_cnt <= r_cnt + 2'd1;
        if (!r_we) r_rdata <= w_last ? w_ext : w_merged;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_issue.sv
// Self-checking bench for lsu_mem_issue: vector table with a response scoreboard,
// plus sequences for split/refused misaligned access, back-to-back and reset abort.
module tb_lsu_mem_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mode;
  logic        mem_we, mem_re, busy;

  lsu_mem_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mode(req_mode),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [7:0] data; logic [2:0] mode;} wr_t;
  typedef struct {logic [31:0] rdata; logic err; int hs; int lat;} exp_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] mode;
    logic [31:0] er; logic ee; int lat; int nwr; int nrd;
  } vec_t;

  logic [7:0] mem [0:255] = '{default: 8'h00};
  wr_t        wlog[$];
  exp_t       sbq[$];
  vec_t       vt[$];
  exp_t       mon_e;
  int         tot = 0, bad = 0, cyc = 0, nrd = 0, nhs = 0;
  logic [7:0] ra, b0, b1, b2, b3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Byte-addressed memory model, little-endian, 256-byte window aliased on addr[7:0].
  always_comb begin
    ra = mem_addr[7:0];
    b0 = mem[ra];
    b1 = mem[ra + 8'd1];
    b2 = mem[ra + 8'd2];
    b3 = mem[ra + 8'd3];
    mem_rdata = '0;
    case (mem_mode)
      `MEM_MODE_B:  mem_rdata = {{24{b0[7]}}, b0};
      `MEM_MODE_BU: mem_rdata = {24'h0, b0};
      `MEM_MODE_H:  mem_rdata = {{16{b1[7]}}, b1, b0};
      `MEM_MODE_HU: mem_rdata = {16'h0, b1, b0};
      `MEM_MODE_W:  mem_rdata = {b3, b2, b1, b0};
      default:      mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) nrd <= nrd + 1;
    if (mem_we) begin
      case (mem_mode)
        `MEM_MODE_B: mem[ra] <= mem_wdata[7:0];
        `MEM_MODE_H: begin
          mem[ra] <= mem_wdata[7:0]; mem[ra + 8'd1] <= mem_wdata[15:8];
        end
        `MEM_MODE_W: begin
          mem[ra] <= mem_wdata[7:0];          mem[ra + 8'd1] <= mem_wdata[15:8];
          mem[ra + 8'd2] <= mem_wdata[23:16]; mem[ra + 8'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
      wlog.push_back('{mem_addr, mem_wdata[7:0], mem_mode});
    end
  end

  always @(negedge clk) begin
    if (req_valid && req_ready) nhs <= nhs + 1;
    chk("ready_vs_busy", 32'(req_ready), 32'(!busy));
    if (mem_we || mem_re) chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
    if (resp_valid) begin
      if (sbq.size() == 0) chk("unexpected_resp", 32'(sbq.size()), 32'd1);
      else begin
        mon_e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        chk("resp_latency", 32'(cyc - mon_e.hs), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] m, input logic [31:0] er, input logic ee,
                       input int lat, input bit hold);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    req_we = we; req_addr = a; req_wdata = wd; req_mode = m; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    if (req_ready) begin
      e.rdata = er; e.err = ee; e.hs = cyc; e.lat = lat;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk);
  endtask

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] m, input logic [31:0] er, input logic ee,
                     input int lat, input int nwr, input int nr);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.mode = m; v.er = er; v.ee = ee;
    v.lat = lat; v.nwr = nwr; v.nrd = nr;
    vt.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          w0, r0, b2b0;
    logic [7:0]  eb [4];
    logic [31:0] raddr;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_mode = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    //  we    addr           wdata          mode         exp_rdata      err lat wr rd
    add(1'b1, 32'h0001_0004, 32'hDEADBEEF, `MEM_MODE_W,  32'h0,         0,  2,  1, 0);
    add(1'b0, 32'h0001_0004, 32'h0,        `MEM_MODE_W,  32'hDEADBEEF,  0,  2,  0, 1);
    add(1'b1, 32'h0001_0001, 32'h0000_0080,`MEM_MODE_B,  32'h0,         0,  2,  1, 0);
    add(1'b0, 32'h0001_0001, 32'h0,        `MEM_MODE_B,  32'hFFFFFF80,  0,  2,  0, 1);
    add(1'b0, 32'h0001_0001, 32'h0,        `MEM_MODE_BU, 32'h00000080,  0,  2,  0, 1);
    add(1'b0, 32'h0001_0004, 32'h0,        `MEM_MODE_H,  32'hFFFFBEEF,  0,  2,  0, 1);
    add(1'b0, 32'h0001_0006, 32'h0,        `MEM_MODE_HU, 32'h0000DEAD,  0,  2,  0, 1);
    add(1'b1, 32'h0001_0008, 32'h0000_1234,`MEM_MODE_H,  32'h0,         0,  2,  1, 0);
    add(1'b0, 32'h0001_0008, 32'h0,        `MEM_MODE_HU, 32'h00001234,  0,  2,  0, 1);
    add(1'b0, 32'h0001_0004, 32'h0,        3'b011,       32'h0,         1,  1,  0, 0);
    add(1'b1, 32'h0001_0004, 32'h55,       `MEM_MODE_BU, 32'h0,         1,  1,  0, 0);
    add(1'b1, 32'h0001_0004, 32'h55,       3'b111,       32'h0,         1,  1,  0, 0);
    add(1'b1, 32'hFFFF_FFFF, 32'h0000_005A,`MEM_MODE_B,  32'h0,         0,  2,  1, 0);
    add(1'b0, 32'hFFFF_FFFF, 32'h0,        `MEM_MODE_BU, 32'h0000005A,  0,  2,  0, 1);
`ifdef LSU_MISALIGN_SPLIT_EN
    add(1'b0, 32'h0001_0002, 32'h0,        `MEM_MODE_W,  32'hBEEF0000,  0,  5,  0, 4);
    add(1'b0, 32'hFFFF_FFFF, 32'h0,        `MEM_MODE_H,  32'h0000005A,  0,  3,  0, 2);
`else
    add(1'b0, 32'h0001_0002, 32'h0,        `MEM_MODE_W,  32'h0,         1,  1,  0, 0);
    add(1'b0, 32'hFFFF_FFFF, 32'h0,        `MEM_MODE_H,  32'h0,         1,  1,  0, 0);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      w0 = wlog.size();
      r0 = nrd;
      issue(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].mode, vt[i].er, vt[i].ee, vt[i].lat, 1'b0);
      drain();
      chk("vec_nwr", 32'(wlog.size() - w0), 32'(vt[i].nwr));
      chk("vec_nrd", 32'(nrd - r0), 32'(vt[i].nrd));
      if (vt[i].nwr == 1) chk("vec_wr_addr", wlog[wlog.size()-1].addr, vt[i].addr);
    end

    // Back-to-back with req_valid held: exactly two handshakes.
    b2b0 = nhs;
    issue(1'b0, 32'h0001_0004, 32'h0, `MEM_MODE_W,  32'hDEADBEEF, 1'b0, 2, 1'b1);
    issue(1'b0, 32'h0001_0001, 32'h0, `MEM_MODE_BU, 32'h00000080, 1'b0, 2, 1'b0);
    drain();
    chk("b2b_handshakes", 32'(nhs - b2b0), 32'd2);

`ifdef LSU_MISALIGN_SPLIT_EN
    w0 = wlog.size();
    issue(1'b1, 32'h0001_0003, 32'h11223344, `MEM_MODE_W, 32'h0, 1'b0, 5, 1'b0);
    drain();
    chk("split_nwr", 32'(wlog.size() - w0), 32'd4);
    eb[0] = 8'h44; eb[1] = 8'h33; eb[2] = 8'h22; eb[3] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      if (wlog.size() >= w0 + 4) begin
        chk("split_wr_addr", wlog[w0+i].addr, 32'h0001_0003 + 32'(i));
        chk("split_wr_data", 32'(wlog[w0+i].data), 32'(eb[i]));
        chk("split_wr_mode", 32'(wlog[w0+i].mode), 32'(`MEM_MODE_B));
      end
    end
    issue(1'b0, 32'h0001_0003, 32'h0, `MEM_MODE_W, 32'h11223344, 1'b0, 5, 1'b0);
    drain();
    raddr = 32'h0001_0021;
`else
    r0 = nrd;
    issue(1'b0, 32'h0001_0001, 32'h0, `MEM_MODE_H, 32'h0, 1'b1, 1, 1'b0);
    drain();
    chk("nosplit_no_mem_re", 32'(nrd - r0), 32'd0);
    raddr = 32'h0001_0020;
`endif

    // Reset during an in-flight store: strobes drop without a clock edge, no response.
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = raddr; req_wdata = 32'hAABBCCDD;
    req_mode = `MEM_MODE_W; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    @(posedge clk);
`endif
    #2;
    chk("abort_pre_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_re", 32'(mem_re), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    chk("abort_ready_after", 32'(req_ready), 32'd1);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("abort_byte0_kept", 32'(mem[8'h21]), 32'h000000DD);
    chk("abort_byte1_none", 32'(mem[8'h22]), 32'h00000000);
`else
    chk("abort_no_write", 32'(mem[8'h20]), 32'h00000000);
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
